// File: rtl/video_mode_ctrl.sv
// Video mode controller: qualifies measured frame timing, hands a stable mode to
// the downstream scaler over a req/ack handshake, and blanks video until locked.
module video_mode_ctrl #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned NOSIG_CYCLES  = 600000,
  parameter logic [9:0]  H_MIN         = 10'd256,
  parameter logic [9:0]  V_MIN         = 10'd200
) (
  input  logic       PCLK_i,
  input  logic       RESET_N_i,
  input  logic       frame_change_i,
  input  logic [9:0] h_total_i,
  input  logic [9:0] v_total_i,
  input  logic [9:0] h_active_i,
  input  logic [9:0] v_active_i,
  input  logic       cfg_ack_i,
  output logic       cfg_req_o,
  output logic [9:0] cfg_h_total_o,
  output logic [9:0] cfg_v_total_o,
  output logic [9:0] cfg_h_active_o,
  output logic [9:0] cfg_v_active_o,
  output logic       cfg_wide_o,
  output logic       mode_locked_o,
  output logic       blank_o,
  output logic [1:0] state_o,
  output logic [7:0] relock_cnt_o
);

  typedef enum logic [1:0] {
    NOSIG   = 2'd0,
    ACQUIRE = 2'd1,
    CONFIG  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [19:0] WDOG_MAX     = 20'(NOSIG_CYCLES);
  localparam logic [3:0]  STABLE_LAST  = 4'(STABLE_FRAMES - 1);
  localparam logic [9:0]  WIDE_H_TOTAL = 10'd682;

  state_t          state_reg, state_next;
  logic [3:0][9:0] sample;
  logic [3:0][9:0] cand_reg, cand_next;
  logic [3:0][9:0] cfg_reg, cfg_next;
  logic [3:0][9:0] last_reg;
  logic [3:0]      stable_reg, stable_next;
  logic [19:0]     wdog_reg, wdog_next;
  logic [7:0]      relock_reg, relock_next;
  logic            wide_reg, wide_next;
  logic            req_reg, req_next;
  logic            abort_reg, abort_next;
  logic            timeout_reg, timeout_next;
  logic            locked_reg, blank_reg;
  logic            abort_now, timeout_now, relock_exit;
  logic [3:0]      cand_eq, cfg_eq;
  logic            cand_match, cfg_match, sample_valid, wdog_expired;

  // Field 0 is h_total so the wide decode can index it directly.
  assign sample = {v_active_i, h_active_i, v_total_i, h_total_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_field_cmp
    assign cand_eq[gi] = (sample[gi] == cand_reg[gi]);
    assign cfg_eq[gi]  = (sample[gi] == cfg_reg[gi]);
  end

  assign cand_match   = &cand_eq;
  assign cfg_match    = &cfg_eq;
  assign sample_valid = (h_total_i >= H_MIN) && (v_total_i >= V_MIN);
  // A frame pulse on the expiry cycle takes precedence over the timeout.
  assign wdog_expired = (wdog_reg == WDOG_MAX) && !frame_change_i;
  assign wdog_next    = frame_change_i ? 20'd0 :
                        (wdog_reg == WDOG_MAX) ? wdog_reg : wdog_reg + 20'd1;

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    stable_next  = stable_reg;
    cfg_next     = cfg_reg;
    wide_next    = wide_reg;
    req_next     = req_reg;
    abort_next   = abort_reg;
    timeout_next = timeout_reg;
    abort_now    = 1'b0;
    timeout_now  = 1'b0;
    relock_exit  = 1'b0;
    case (state_reg)
      NOSIG: begin
        if (frame_change_i && sample_valid) begin
          cand_next   = sample;
          stable_next = 4'd0;
          state_next  = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (frame_change_i) begin
          if (!sample_valid) begin
            state_next = NOSIG;
          end else if (cand_match) begin
            if (stable_reg == STABLE_LAST) begin
              cfg_next     = cand_reg;
              wide_next    = (cand_reg[0] == WIDE_H_TOTAL);
              req_next     = 1'b1;
              abort_next   = 1'b0;
              timeout_next = 1'b0;
              state_next   = CONFIG;
            end else begin
              stable_next = stable_reg + 4'd1;
            end
          end else begin
            cand_next   = sample;
            stable_next = 4'd0;
          end
        end else if (wdog_expired) begin
          state_next = NOSIG;
        end
      end
      CONFIG: begin
        abort_now    = abort_reg || (frame_change_i && (!sample_valid || !cfg_match));
        timeout_now  = timeout_reg || wdog_expired;
        abort_next   = abort_now;
        timeout_next = timeout_now;
        if (cfg_ack_i) begin
          req_next     = 1'b0;
          abort_next   = 1'b0;
          timeout_next = 1'b0;
          if (timeout_now) begin
            state_next = NOSIG;
          end else if (abort_now) begin
            cand_next   = frame_change_i ? sample : last_reg;
            stable_next = 4'd0;
            state_next  = ACQUIRE;
          end else begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (frame_change_i) begin
          if (!sample_valid) begin
            state_next  = NOSIG;
            relock_exit = 1'b1;
          end else if (!cfg_match) begin
            cand_next   = sample;
            stable_next = 4'd0;
            state_next  = ACQUIRE;
            relock_exit = 1'b1;
          end
        end else if (wdog_expired) begin
          state_next  = NOSIG;
          relock_exit = 1'b1;
        end
      end
      default: state_next = NOSIG;
    endcase
  end

  assign relock_next = (relock_exit && relock_reg != 8'hFF) ? relock_reg + 8'd1 : relock_reg;

  always_ff @(posedge PCLK_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      state_reg   <= NOSIG;
      cand_reg    <= '0;
      cfg_reg     <= '0;
      last_reg    <= '0;
      stable_reg  <= 4'd0;
      wdog_reg    <= 20'd0;
      relock_reg  <= 8'd0;
      wide_reg    <= 1'b0;
      req_reg     <= 1'b0;
      abort_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      locked_reg  <= 1'b0;
      blank_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cfg_reg     <= cfg_next;
      if (frame_change_i) last_reg <= sample;
      stable_reg  <= stable_next;
      wdog_reg    <= wdog_next;
      relock_reg  <= relock_next;
      wide_reg    <= wide_next;
      req_reg     <= req_next;
      abort_reg   <= abort_next;
      timeout_reg <= timeout_next;
      locked_reg  <= (state_next == LOCKED);
      blank_reg   <= (state_next != LOCKED);
    end
  end

  assign state_o        = state_reg;
  assign cfg_req_o      = req_reg;
  assign cfg_h_total_o  = cfg_reg[0];
  assign cfg_v_total_o  = cfg_reg[1];
  assign cfg_h_active_o = cfg_reg[2];
  assign cfg_v_active_o = cfg_reg[3];
  assign cfg_wide_o     = wide_reg;
  assign mode_locked_o  = locked_reg;
  assign blank_o        = blank_reg;
  assign relock_cnt_o   = relock_reg;

endmodule
